// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: latch enables and bubbles, data-memory
// request sequencing until dhit, load-use detection, taken-branch squash and sticky halt.
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_ren,
    input  logic             mem_wen,
    input  logic             mem_halt,
    input  logic             mem_br_taken,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             dREN,
    output logic             dWEN,
    output logic             imemREN,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, HALTED = 2'd2} state_t;

    state_t state, state_n;
    logic   access, load_use, stall_inc, flush_inc;

    assign access    = mem_ren | mem_wen;
    assign load_use  = idex_memread && (idex_rt != '0) &&
                       ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    assign halt      = (state == HALTED);
    assign state_dbg = state;

    // Data request handshake: dREN/dWEN act as valid and are held steady, with the whole
    // pipeline frozen, until dhit (ready) is seen; the request is consumed in the dhit cycle.
    always_comb begin
        state_n     = state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        dREN        = 1'b0;
        dWEN        = 1'b0;
        imemREN     = 1'b0;
        flush_inc   = 1'b0;
        case (state)
            RUN, DWAIT: begin
                imemREN = 1'b1;
                dREN    = mem_ren;
                dWEN    = mem_wen;
                if (access && !dhit) begin
                    state_n = DWAIT;
                end else begin
                    state_n = RUN;
                    if (mem_halt) begin
                        imemREN = 1'b0;
                        state_n = HALTED;
                    end else if (mem_br_taken) begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        idex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (load_use) begin
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else if (!ihit) begin
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
            end
            default: state_n = HALTED;
        endcase
        // Strobes and bubbles must be quiet while reset is held, independent of the clock.
        if (!nRST) begin
            dREN        = 1'b0;
            dWEN        = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
        end
    end

    assign stall_inc = (state != HALTED) && !pc_en;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_n;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a rule-level model of the hazard controller.
module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       ihit, dhit, mem_ren, mem_wen, mem_halt, mem_br_taken, idex_memread;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, dREN, dWEN, imemREN, halt;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  state_dbg;

    pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_halt(mem_halt), .mem_br_taken(mem_br_taken), .idex_memread(idex_memread),
        .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .pc_en(pc_en),
        .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .dREN(dREN), .dWEN(dWEN), .imemREN(imemREN), .halt(halt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, dREN, dWEN, imemREN, halt}
    wire [11:0] act_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                         ifid_flush, idex_flush, exmem_flush, dREN, dWEN, imemREN, halt};

    logic [11:0] exp_q[$];
    logic [11:0] exp_v;
    int checks = 0;
    int errors = 0;

    // Model state: waiting on memory, halted, and the two performance counters.
    bit m_wait, m_halt;
    int m_stall, m_flush;
    bit has_pending, p_wait, p_halt, p_stall_inc, p_flush_inc;

    function automatic logic [11:0] model_eval();
        logic [11:0] e = '0;
        bool_dummy: begin end
        p_wait = 1'b0; p_halt = m_halt; p_flush_inc = 1'b0;
        if (m_halt) begin
            e[0] = 1'b1;
        end else begin
            e[1] = 1'b1; e[3] = mem_ren; e[2] = mem_wen;
            if ((mem_ren || mem_wen) && !dhit) begin
                p_wait = 1'b1;
            end else if (mem_halt) begin
                e[1] = 1'b0; p_halt = 1'b1;
            end else if (mem_br_taken) begin
                e[11:4] = 8'hFF; p_flush_inc = 1'b1;
            end else if (idex_memread && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt)) begin
                e[9] = 1'b1; e[8] = 1'b1; e[7] = 1'b1; e[5] = 1'b1;
            end else if (!ihit) begin
                e[9] = 1'b1; e[8] = 1'b1; e[7] = 1'b1; e[6] = 1'b1;
            end else begin
                e[11:7] = 5'b11111;
            end
        end
        p_stall_inc = !m_halt && !e[11];
        has_pending = 1'b1;
        return e;
    endfunction

    task automatic advance();
        @(negedge CLK);
        if (has_pending) begin
            m_wait = p_wait;
            m_halt = p_halt;
            if (p_stall_inc && m_stall < 65535) m_stall++;
            if (p_flush_inc && m_flush < 65535) m_flush++;
            has_pending = 1'b0;
        end
    endtask

    task automatic apply(input bit ih, dh, rn, wn, hl, br, mr, input logic [4:0] irt, rs, rt);
        ihit = ih; dhit = dh; mem_ren = rn; mem_wen = wn; mem_halt = hl;
        mem_br_taken = br; idex_memread = mr; idex_rt = irt; ifid_rs = rs; ifid_rt = rt;
        #1;
        exp_q.push_back(model_eval());
    endtask

    task automatic cyc(input bit ih, dh, rn, wn, hl, br, mr, input logic [4:0] irt, rs, rt);
        advance();
        apply(ih, dh, rn, wn, hl, br, mr, irt, rs, rt);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        ihit = 1'b1; dhit = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_halt = 1'b0;
        mem_br_taken = 1'b0; idex_memread = 1'b0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
        m_wait = 0; m_halt = 0; m_stall = 0; m_flush = 0; has_pending = 0;
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        ihit = 1'b0; dhit = 1'b0; mem_ren = 1'b1; mem_wen = 1'b1; mem_halt = 1'b0;
        mem_br_taken = 1'b1; idex_memread = 1'b0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
        #7;
        checks++;
        if ({dREN, dWEN, ifid_flush, idex_flush, exmem_flush} !== 5'b0) begin
            errors++; $display("FAIL reset_quiet: strobes/flushes=%b required 00000",
                               {dREN, dWEN, ifid_flush, idex_flush, exmem_flush});
        end
        checks++;
        if ({stall_cnt, flush_cnt, halt} !== 33'b0) begin
            errors++; $display("FAIL reset_state: stall=%0d flush=%0d halt=%b required 0 0 0",
                               stall_cnt, flush_cnt, halt);
        end
        do_reset();
    endtask

    task automatic test_load_wait();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1, i == 3, i < 4, 0, 0, 0, 0, 0, 0, 0);
            exp_v = exp_q.pop_front();
            checks++;
            if (((act_v ^ exp_v) & ~{1'b0, exp_v[6:4], 8'h00}) !== 12'h0) begin
                errors++; $display("FAIL load_wait cyc%0d: ctrl=%b expected %b", i, act_v, exp_v);
            end
            checks++;
            if (dREN !== (i < 4) || pc_en !== (i >= 3)) begin
                errors++; $display("FAIL load_wait_strobe cyc%0d: dREN=%b pc_en=%b", i, dREN, pc_en);
            end
        end
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++; $display("FAIL load_wait_stalls: stall_cnt=%0d required 3", stall_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 1, 5'd2, 5'd2, 5'd4);
        exp_v = exp_q.pop_front();
        checks++;
        if (((act_v ^ exp_v) & ~{1'b0, exp_v[6:4], 8'h00}) !== 12'h0 || pc_en !== 1'b0 || idex_flush !== 1'b1) begin
            errors++; $display("FAIL load_use: ctrl=%b expected %b", act_v, exp_v);
        end
        cyc(1, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (((act_v ^ exp_v) & ~{1'b0, exp_v[6:4], 8'h00}) !== 12'h0 || pc_en !== 1'b1) begin
            errors++; $display("FAIL zero_reg_no_stall: ctrl=%b expected %b", act_v, exp_v);
        end
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++; $display("FAIL load_use_count: stall_cnt=%0d required 1", stall_cnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        exp_v = exp_q.pop_front();
        checks++;
        if (act_v !== exp_v || pc_en !== 1'b1 || {ifid_flush, idex_flush, exmem_flush} !== 3'b111) begin
            errors++; $display("FAIL branch: ctrl=%b expected %b", act_v, exp_v);
        end
        cyc(1, 0, 0, 0, 0, 1, 1, 5'd7, 5'd3, 5'd7);
        exp_v = exp_q.pop_front();
        checks++;
        if (act_v !== exp_v || pc_en !== 1'b1) begin
            errors++; $display("FAIL branch_vs_load_use: ctrl=%b expected %b", act_v, exp_v);
        end
        advance();
        checks++;
        if (flush_cnt !== 16'd2 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL branch_counts: flush=%0d stall=%0d required 2 0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_halt();
        do_reset();
        cyc(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        exp_v = exp_q.pop_front();
        checks++;
        if (act_v !== exp_v || dWEN !== 1'b1 || pc_en !== 1'b0) begin
            errors++; $display("FAIL halt_wait: ctrl=%b expected %b", act_v, exp_v);
        end
        cyc(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        exp_v = exp_q.pop_front();
        checks++;
        if (act_v !== exp_v || imemREN !== 1'b0) begin
            errors++; $display("FAIL halt_dhit: ctrl=%b expected %b", act_v, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1, 1, 0, 1, 0, 0, 0, 0);
            exp_v = exp_q.pop_front();
            checks++;
            if (act_v !== exp_v || act_v !== 12'h001) begin
                errors++; $display("FAIL halted cyc%0d: ctrl=%b expected %b", i, act_v, exp_v);
            end
        end
        checks++;
        if (stall_cnt !== 16'd2 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL halted_counts: stall=%0d flush=%0d required 2 0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_reset_dwait();
        do_reset();
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        void'(exp_q.pop_front());
        #2 nRST = 1'b0;
        #1;
        checks++;
        if (dREN !== 1'b0) begin
            errors++; $display("FAIL reset_dwait_strobe: dREN=%b required 0", dREN);
        end
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_v = exp_q.pop_front();
        checks++;
        if (act_v !== exp_v || act_v !== 12'hF82) begin
            errors++; $display("FAIL reset_dwait_run: ctrl=%b expected %b", act_v, exp_v);
        end
    endtask

    task automatic test_random();
        bit rn, wn, hl, br;
        do_reset();
        rn = 0; wn = 0; hl = 0; br = 0;
        for (int i = 0; i < 3000; i++) begin
            advance();
            if (m_halt && $urandom_range(0, 3) == 0) begin
                do_reset();
                advance();
            end
            if (!m_wait) begin
                rn = ($urandom_range(0, 99) < 20);
                wn = !rn && ($urandom_range(0, 99) < 15);
                hl = ($urandom_range(0, 99) < 2);
                br = ($urandom_range(0, 99) < 15);
            end
            apply($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 40, rn, wn, hl, br,
                  $urandom_range(0, 99) < 40, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            exp_v = exp_q.pop_front();
            checks++;
            if (((act_v ^ exp_v) & ~{1'b0, exp_v[6:4], 8'h00}) !== 12'h0) begin
                errors++; $display("FAIL random cyc%0d: ctrl=%b expected %b", i, act_v, exp_v);
            end
            if (i % 50 == 0) begin
                checks++;
                if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
                    errors++; $display("FAIL random_counts cyc%0d: stall=%0d flush=%0d expected %0d %0d",
                                       i, stall_cnt, flush_cnt, m_stall, m_flush);
                end
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            void'(exp_q.pop_front());
        end
        advance();
        checks++;
        if (stall_cnt !== 16'hFFFF || m_stall != 65535) begin
            errors++; $display("FAIL stall_saturate: stall_cnt=%h required ffff", stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_wait();
        test_load_use();
        test_branch();
        test_halt();
        test_reset_dwait();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
